// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM AXI arbiter.
package sram_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, RSP} state_t;
endpackage

// File: rtl/sram_axi_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin grant with a registered last-grant pointer.
module rr_arbiter2 import sram_arb_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic               idx
);
  logic last;
  always_comb begin
    idx = &valid ? !last : valid[1];
    grant = valid & (idx ? 2'b10 : 2'b01);
  end
  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last <= 1'b1;
    else if (en) last <= idx;
endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares one AXI-Lite SRAM slave port between two requesters,
// one transaction in flight, responses routed back to the granted requester.
module sram_axi_arbiter import sram_arb_pkg::*; #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_BITS-1:0]         rsp_rdata,
  output logic [ADDR_BITS-1:0]         s_axi_awaddr,
  output logic                         s_axi_awvalid,
  input  logic                         s_axi_awready,
  output logic [DATA_BITS-1:0]         s_axi_wdata,
  output logic                         s_axi_wvalid,
  input  logic                         s_axi_wready,
  input  logic                         s_axi_bvalid,
  output logic                         s_axi_bready,
  output logic [ADDR_BITS-1:0]         s_axi_araddr,
  output logic                         s_axi_arvalid,
  input  logic                         s_axi_arready,
  input  logic [DATA_BITS-1:0]         s_axi_rdata,
  input  logic                         s_axi_rvalid,
  output logic                         s_axi_rready
);
  state_t state, state_nx;
  logic [NUM_REQ-1:0] arb_grant;
  logic arb_idx, grant, take;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .valid(req_valid),
    .en(take),
    .grant(arb_grant),
    .idx(arb_idx)
  );
  // Gated by reset_n so no grant is offered while the block is held in reset.
  assign req_ready = (reset_n && state == IDLE) ? arb_grant : '0;
  assign take = |req_ready;
  assign s_axi_awaddr = addr;
  assign s_axi_araddr = addr;
  assign s_axi_wdata = wdata;
  assign s_axi_arvalid = state == RD_ADDR;
  assign s_axi_bready = state == WR_RESP;
  assign s_axi_rready = state == RD_RESP;
  assign rsp_valid = (state == RSP) ? (grant ? 2'b10 : 2'b01) : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = req_we[arb_idx] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((!s_axi_awvalid || s_axi_awready) && (!s_axi_wvalid || s_axi_wready)) state_nx = WR_RESP;
      WR_RESP: if (s_axi_bvalid) state_nx = RSP;
      RD_ADDR: if (s_axi_arready) state_nx = RD_RESP;
      RD_RESP: if (s_axi_rvalid) state_nx = RSP;
      RSP:     if (rsp_ready[grant]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      grant <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rsp_rdata <= '0;
      s_axi_awvalid <= 1'b0;
      s_axi_wvalid <= 1'b0;
    end else begin
      if (state == WR_ADDR && s_axi_awready) s_axi_awvalid <= 1'b0;
      if (state == WR_ADDR && s_axi_wready) s_axi_wvalid <= 1'b0;
      if (state == WR_RESP && s_axi_bvalid) rsp_rdata <= '0;
      if (state == RD_RESP && s_axi_rvalid) rsp_rdata <= s_axi_rdata;
      if (take) begin
        grant <= arb_idx;
        addr <= arb_idx ? req_addr[2*ADDR_BITS-1:ADDR_BITS] : req_addr[ADDR_BITS-1:0];
        wdata <= arb_idx ? req_wdata[2*DATA_BITS-1:DATA_BITS] : req_wdata[DATA_BITS-1:0];
        s_axi_awvalid <= req_we[arb_idx];
        s_axi_wvalid <= req_we[arb_idx];
      end
    end
endmodule
